// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl
//   Drives a 16-bit parallel-output ADC through its conversion sequence:
//   1. pulse CONVST low,
//   2. wait for EOC,
//   3. strobe CS/RD low and capture DB,
//   4. present the word with a one-cycle valid.
//   Conversions start on a single-shot request, or periodically while
//   continuous sampling is enabled.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous reset, active-high
//   i_enable         continuous sampling enable
//   i_start          single-shot request pulse, accepted only in IDLE
//   i_sample_period  cycles between CONVST falling edges in continuous mode
//   i_eoc_n          ADC end-of-conversion, active-low, asynchronous
//   i_db             ADC data bus
//   o_convst_n       conversion start strobe, active-low
//   o_cs_n           chip select, active-low
//   o_rd_n           read strobe, active-low
//   o_wr_n           write strobe, held high
//   o_shdn           ADC shutdown, high only while in reset
//   o_sample         last captured word
//   o_sample_valid   one-cycle pulse per captured word
//   o_timeout_err    sticky EOC timeout flag
//   o_busy           high whenever a sequence is in progress
module adc_seq_ctrl #(
    parameter int CONV_LOW    = 4,
    parameter int RD_LOW      = 3,
    parameter int EOC_TIMEOUT = 1000,
    parameter int PERIOD_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic [PERIOD_W-1:0] i_sample_period,
    input  logic                i_eoc_n,
    input  logic [15:0]         i_db,
    output logic                o_convst_n,
    output logic                o_cs_n,
    output logic                o_rd_n,
    output logic                o_wr_n,
    output logic                o_shdn,
    output logic [15:0]         o_sample,
    output logic                o_sample_valid,
    output logic                o_timeout_err,
    output logic                o_busy
);

    // The phase counter times CONV, READ and the EOC timeout, so it is sized
    // for the longest of the three.
    localparam int CNT_MAX = (EOC_TIMEOUT > CONV_LOW)
                           ? ((EOC_TIMEOUT > RD_LOW) ? EOC_TIMEOUT : RD_LOW)
                           : ((CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_LOW - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_LOW - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(EOC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT_EOC,
        S_READ,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_phase_cnt;
    logic [PERIOD_W-1:0]   r_period_cnt;
    logic                  r_eoc_s1;
    logic                  r_eoc_s2;
    logic                  r_eoc_s3;
    logic                  r_shdn;
    logic [15:0]           r_sample;
    logic                  r_timeout_err;
    logic                  w_eoc_fall;
    logic                  w_trigger;
    logic                  w_launch;
    logic                  w_accept_start;
    logic                  w_timeout;
    logic                  w_rd_strobe_n;

    // eoc_n is asynchronous to clk, so it passes through two flops first.
    // The third flop only remembers the previous synchronized level, which
    // lets us detect the falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_eoc_s1 <= 1'b1;
            r_eoc_s2 <= 1'b1;
            r_eoc_s3 <= 1'b1;
        end else begin
            r_eoc_s1 <= i_eoc_n;
            r_eoc_s2 <= r_eoc_s1;
            r_eoc_s3 <= r_eoc_s2;
        end
    end

    assign w_eoc_fall     = r_eoc_s3 & ~r_eoc_s2;
    // A start pulse and an expired period together still launch only one conversion.
    assign w_trigger      = i_start | (i_enable & (r_period_cnt == '0));
    assign w_launch       = (r_state == S_IDLE) & w_trigger;
    assign w_accept_start = (r_state == S_IDLE) & i_start;
    assign w_timeout      = (r_state == S_WAIT_EOC) & ~w_eoc_fall & (r_phase_cnt == TO_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_trigger) w_state_next = S_CONV;
            S_CONV:     if (r_phase_cnt == CONV_LAST) w_state_next = S_WAIT_EOC;
            S_WAIT_EOC: begin
                // An EOC edge that arrives on the final timeout cycle still wins.
                if (w_eoc_fall) begin
                    w_state_next = S_READ;
                end else if (r_phase_cnt == TO_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            S_READ:     if (r_phase_cnt == RD_LAST) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Output logic: the strobes are pure functions of the state.
    // Because of that, CONVST and CS can never be low together.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        o_convst_n     = 1'b1;
        w_rd_strobe_n  = 1'b1;
        o_sample_valid = 1'b0;
        o_busy         = 1'b1;
        case (r_state)
            S_IDLE:  o_busy         = 1'b0;
            S_CONV:  o_convst_n     = 1'b0;
            S_READ:  w_rd_strobe_n  = 1'b0;
            S_DONE:  o_sample_valid = 1'b1;
            default: ;
        endcase
    end

    // Cycles spent in the current state; the counter restarts on every state change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase_cnt <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
            r_phase_cnt <= '0;
        end else begin
            r_phase_cnt <= r_phase_cnt + CNT_W'(1);
        end
    end

    // The period counter starts running at CONV entry and saturates at zero.
    // A programmed period of 0 behaves like 1, giving back-to-back sequences.
    // A sequence longer than the period simply stretches the effective period.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period_cnt <= '0;
        end else if (w_launch) begin
            r_period_cnt <= (i_sample_period == '0) ? '0 : i_sample_period - PERIOD_W'(1);
        end else if (r_period_cnt != '0) begin
            r_period_cnt <= r_period_cnt - PERIOD_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample      <= '0;
            r_timeout_err <= 1'b0;
            r_shdn        <= 1'b1;
        end else begin
            r_shdn <= 1'b0;
            // DB is captured on the last cycle of the read strobe.
            if ((r_state == S_READ) && (r_phase_cnt == RD_LAST)) begin
                r_sample <= i_db;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (w_accept_start) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_cs_n        = w_rd_strobe_n;
    assign o_rd_n        = w_rd_strobe_n;
    assign o_wr_n        = 1'b1;
    assign o_shdn        = r_shdn;
    assign o_sample      = r_sample;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb_adc_seq_ctrl
//   Self-checking bench for adc_seq_ctrl.
//   A behavioural ADC drives eoc_n and db after each CONVST pulse.
//   A negedge monitor checks pin invariants and strobe widths, and logs the
//   cycle of every event.
//   The test sequence compares those logs against timing computed from the
//   sequencer's rules:
//     - latency,
//     - effective period,
//     - conversion counts.
module tb_adc_seq_ctrl;

    localparam int CONV_LOW    = 4;
    localparam int RD_LOW      = 3;
    localparam int EOC_TIMEOUT = 1000;
    localparam int PERIOD_W    = 16;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b1;
    logic                i_enable = 1'b0;
    logic                i_start = 1'b0;
    logic [PERIOD_W-1:0] i_sample_period = '0;
    logic                i_eoc_n;
    logic [15:0]         i_db;
    logic                o_convst_n;
    logic                o_cs_n;
    logic                o_rd_n;
    logic                o_wr_n;
    logic                o_shdn;
    logic [15:0]         o_sample;
    logic                o_sample_valid;
    logic                o_timeout_err;
    logic                o_busy;

    adc_seq_ctrl #(
        .CONV_LOW    (CONV_LOW),
        .RD_LOW      (RD_LOW),
        .EOC_TIMEOUT (EOC_TIMEOUT),
        .PERIOD_W    (PERIOD_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_enable        (i_enable),
        .i_start         (i_start),
        .i_sample_period (i_sample_period),
        .i_eoc_n         (i_eoc_n),
        .i_db            (i_db),
        .o_convst_n      (o_convst_n),
        .o_cs_n          (o_cs_n),
        .o_rd_n          (o_rd_n),
        .o_wr_n          (o_wr_n),
        .o_shdn          (o_shdn),
        .o_sample        (o_sample),
        .o_sample_valid  (o_sample_valid),
        .o_timeout_err   (o_timeout_err),
        .o_busy          (o_busy)
    );

    int total = 0;
    int bad   = 0;

    int   cyc   = 0;
    logic rst_q = 1'b1;

    // Event logs and the expected-data scoreboard
    int          fall_q[$];
    int          valid_q[$];
    logic [15:0] exp_q[$];

    // ADC model controls
    bit          adc_en    = 1'b0;
    bit          adc_rand  = 1'b0;
    int          adc_delay = 10;
    logic [15:0] adc_word  = 16'hA5C3;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Reference timing, straight from the sequencing rules.
    // start -> valid: CONV_LOW + (t + 3 sync/edge cycles) + RD_LOW + DONE.
    function automatic int seq_len(input int t);
        return CONV_LOW + t + 3 + RD_LOW + 1;
    endfunction

    // Period between launches: the programmed period, or one full sequence
    // plus a single IDLE cycle, whichever is longer.
    function automatic int period_eff(input int p, input int t);
        int pp;
        pp = (p == 0) ? 1 : p;
        return (pp > seq_len(t) + 1) ? pp : seq_len(t) + 1;
    endfunction

    // Behavioural ADC: eoc_n drops adc_delay cycles after CONVST rises.
    // The new word appears on db at that moment.
    initial begin
        logic [15:0] w;
        i_eoc_n = 1'b1;
        i_db    = '0;
        forever begin
            @(posedge o_convst_n);
            if (adc_en) begin
                repeat (adc_delay) @(posedge i_clk);
                #1;
                w = adc_rand ? 16'($urandom) : adc_word;
                i_db = w;
                exp_q.push_back(w);
                i_eoc_n = 1'b0;
                repeat (4) @(posedge i_clk);
                #1 i_eoc_n = 1'b1;
            end
        end
    end

    // Pin monitor, sampled away from the active edge
    int   conv_run    = 0;
    int   rd_run      = 0;
    logic prev_convst = 1'b1;
    logic prev_valid  = 1'b0;

    always @(negedge i_clk) begin
        check("wr_n_high", o_wr_n, 1);
        check("shdn", o_shdn, rst_q);
        check("cs_rd_pair", o_cs_n, o_rd_n);
        check("convst_cs_overlap", (!o_convst_n && !o_cs_n), 0);
        check("valid_one_cycle", (prev_valid && o_sample_valid), 0);
        if (rst_q) begin
            check("reset_strobes", {o_convst_n, o_cs_n, o_sample_valid, o_busy}, 4'b1100);
        end
        if (!o_convst_n) begin
            if (prev_convst) fall_q.push_back(cyc);
            conv_run++;
        end else if (conv_run > 0) begin
            check("convst_width", conv_run, CONV_LOW);
            conv_run = 0;
        end
        if (!o_cs_n) begin
            rd_run++;
        end else if (rd_run > 0) begin
            if (!rst_q) check("rd_width", rd_run, RD_LOW);
            rd_run = 0;
        end
        if (o_sample_valid) begin
            valid_q.push_back(cyc);
            check("sample_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sample_data", o_sample, exp_q.pop_front());
        end
        prev_convst = o_convst_n;
        prev_valid  = o_sample_valid;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check("busy_bound", o_busy, 0);
    endtask

    task automatic single_shot(input int t);
        int n, v0, f0, c;
        adc_delay = t;
        v0 = valid_q.size();
        f0 = fall_q.size();
        n = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle(2000, c);
        check("ss_idle_cycle", c - n, seq_len(t) + 1);
        check("ss_valid_count", valid_q.size() - v0, 1);
        if (valid_q.size() > v0) check("ss_latency", valid_q[v0] - n, seq_len(t));
        if (fall_q.size() > f0) check("ss_convst_fall", fall_q[f0] - n, 1);
        check("ss_timeout_flag", o_timeout_err, 0);
    endtask

    task automatic continuous(input int p, input int t);
        int e, f0, v0, c, nexp;
        apply_reset();
        adc_delay = t;
        i_sample_period = PERIOD_W'(p);
        f0 = fall_q.size();
        v0 = valid_q.size();
        e = cyc;
        i_enable = 1'b1;
        repeat (500) tick();
        i_enable = 1'b0;
        wait_idle(2000, c);
        // A launch is triggered in cycles e, e+P, ... for as long as enable is high.
        nexp = 499 / period_eff(p, t) + 1;
        check("cont_convs", fall_q.size() - f0, nexp);
        check("cont_valids", valid_q.size() - v0, nexp);
        if (fall_q.size() > f0) check("cont_first_fall", fall_q[f0] - e, 1);
        for (int k = f0 + 1; k < fall_q.size(); k++) begin
            check("cont_period", fall_q[k] - fall_q[k-1], period_eff(p, t));
        end
        repeat (40) tick();
        check("cont_stays_idle", fall_q.size() - f0, nexp);
    endtask

    initial begin
        int n, c, v0, f0;

        // Reset values
        i_rst = 1'b1;
        tick();
        tick();
        check("rst_convst_n", o_convst_n, 1);
        check("rst_cs_n", o_cs_n, 1);
        check("rst_rd_n", o_rd_n, 1);
        check("rst_wr_n", o_wr_n, 1);
        check("rst_shdn", o_shdn, 1);
        check("rst_sample", o_sample, 0);
        check("rst_valid", o_sample_valid, 0);
        check("rst_timeout", o_timeout_err, 0);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        tick();
        tick();
        check("shdn_released", o_shdn, 0);

        // Single shot with a fixed word
        adc_en   = 1'b1;
        adc_rand = 1'b0;
        adc_word = 16'hA5C3;
        single_shot(10);
        check("ss_sample_word", o_sample, 16'hA5C3);
        check("ss_busy_after", o_busy, 0);

        // Reset asserted on the second read-strobe cycle
        v0 = valid_q.size();
        adc_delay = 10;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (!o_cs_n) break;
        end
        check("rr_cs_seen", o_cs_n, 0);
        tick();
        check("rr_second_low", o_rd_n, 0);
        i_rst = 1'b1;
        tick();
        check("rr_cs_n", o_cs_n, 1);
        check("rr_rd_n", o_rd_n, 1);
        check("rr_sample", o_sample, 0);
        check("rr_busy", o_busy, 0);
        check("rr_valid", o_sample_valid, 0);
        i_rst = 1'b0;
        repeat (30) tick();
        check("rr_no_valid", valid_q.size() - v0, 0);
        exp_q.delete();

        // Randomized single shots
        adc_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            single_shot(int'($urandom_range(0, 40)));
            repeat ($urandom_range(0, 5)) tick();
        end

        // A start during WAIT_EOC is ignored
        apply_reset();
        adc_delay = 10;
        f0 = fall_q.size();
        v0 = valid_q.size();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle(2000, c);
        repeat (40) tick();
        check("ign_convs", fall_q.size() - f0, 1);
        check("ign_valids", valid_q.size() - v0, 1);

        // start and enable in the same cycle count as one conversion
        apply_reset();
        f0 = fall_q.size();
        i_sample_period = 16'd1000;
        i_enable = 1'b1;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (100) tick();
        i_enable = 1'b0;
        wait_idle(2000, c);
        check("start_enable_one", fall_q.size() - f0, 1);

        // EOC timeout, then cleared by the next accepted start
        apply_reset();
        adc_en = 1'b0;
        v0 = valid_q.size();
        n = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle(EOC_TIMEOUT + 100, c);
        check("to_idle_cycle", c - n, 1 + CONV_LOW + EOC_TIMEOUT);
        check("to_flag_set", o_timeout_err, 1);
        check("to_no_valid", valid_q.size() - v0, 0);
        repeat (5) tick();
        check("to_flag_sticky", o_timeout_err, 1);
        adc_en = 1'b1;
        adc_delay = 5;
        v0 = valid_q.size();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("to_flag_cleared", o_timeout_err, 0);
        wait_idle(2000, c);
        check("to_recover_valid", valid_q.size() - v0, 1);

        // Continuous sampling
        continuous(100, 10);
        continuous(0, 10);
        continuous(int'($urandom_range(0, 60)), int'($urandom_range(0, 20)));
        continuous(int'($urandom_range(20, 90)), int'($urandom_range(0, 20)));

        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
